booth_r4_mac_seq: RTL and testbench

Parametrised sequential radix-4 Booth multiply-accumulate unit for the APB MAC datapath. It retires one Booth digit per clock. It supports signed and unsigned operands and a widened, saturation-free accumulator with sticky overflow. A start/busy/done handshake allows back-to-back operations. It replaces the fixed 8-bit unsigned-only multiplier as the compute core behind the APB register file.

---
 rtl/booth_mac_pkg.sv | 14 +
 rtl/booth_r4_digit_enc.sv | 29 ++
 rtl/booth_r4_mac_seq.sv | 141 ++++++++++++++
 tb/tb_booth_r4_mac_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth MAC.
// Holds the FSM state enum, the Booth digit enum and the digit-count function.
package booth_mac_pkg;

    typedef enum logic [1:0] {IDLE, CALC, ACC} state_t;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG2, NEG1} booth_digit_t;

    // One extra digit covers the extension bits, so unsigned operands need no special case.
    function automatic int digitCount(input int opW);
        return opW / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: maps one overlapping 3-bit multiplier group
// to a signed digit expressed as {neg, one, two}.
module booth_r4_digit_enc
    import booth_mac_pkg::*;
(
    input  logic [2:0] i_group,
    output logic       o_neg,
    output logic       o_one,
    output logic       o_two
);

    booth_digit_t w_digit;

    always_comb begin
        w_digit = ZERO;
        case (i_group)
            3'b001, 3'b010: w_digit = POS1;
            3'b011:         w_digit = POS2;
            3'b100:         w_digit = NEG2;
            3'b101, 3'b110: w_digit = NEG1;
            default:        w_digit = ZERO;
        endcase
    end

    assign o_neg = (w_digit == NEG1) || (w_digit == NEG2);
    assign o_one = (w_digit == POS1) || (w_digit == NEG1);
    assign o_two = (w_digit == POS2) || (w_digit == NEG2);

endmodule

// File: rtl/booth_r4_mac_seq.sv
// Sequential radix-4 Booth multiply-accumulate: one Booth digit per clock,
// signed/unsigned operands, wrapping accumulator with sticky overflow.
module booth_r4_mac_seq
    import booth_mac_pkg::*;
#(
    parameter int OP_W  = 8,
    parameter int ACC_W = 2 * OP_W + 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_mode,
    input  logic                acc_clr,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   product,
    output logic [ACC_W-1:0]    acc,
    output logic                ovf
);

    localparam int N  = digitCount(OP_W);
    localparam int SW = 2 * OP_W + 2;
    localparam int CW = $clog2(N + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [OP_W-1:0]     r_a;
    logic [OP_W+2:0]     r_bExt;
    logic                r_signed;
    logic                r_accClr;
    logic [SW-1:0]       r_sum;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    logic [2*OP_W-1:0]   r_product;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;

    logic [2:0]          w_group;
    logic                w_neg;
    logic                w_one;
    logic                w_two;
    logic [SW-1:0]       w_aExt;
    logic [SW-1:0]       w_mag;
    logic [SW-1:0]       w_term;
    logic [SW-1:0]       w_addend;
    logic [2*OP_W-1:0]   w_prod;
    logic [ACC_W-1:0]    w_ext;
    logic [ACC_W:0]      w_accSum;
    logic                w_signedOvf;
    logic [ACC_W-1:0]    w_accNext;
    logic                w_ovfNext;

    assign w_group = 3'(r_bExt >> {r_cnt, 1'b0});

    booth_r4_digit_enc u_enc (
        .i_group (w_group),
        .o_neg   (w_neg),
        .o_one   (w_one),
        .o_two   (w_two)
    );

    assign w_aExt   = r_signed ? SW'(signed'(r_a)) : SW'(r_a);
    assign w_mag    = w_two ? (w_aExt << 1) : (w_one ? w_aExt : '0);
    assign w_term   = w_neg ? (-w_mag) : w_mag;
    assign w_addend = w_term << {r_cnt, 1'b0};

    // Accumulate step: the carry out of the widened sum is the unsigned overflow flag.
    assign w_prod      = r_sum[2*OP_W-1:0];
    assign w_ext       = r_signed ? ACC_W'(signed'(w_prod)) : ACC_W'(w_prod);
    assign w_accSum    = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_signedOvf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                         (w_accSum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_accNext   = r_accClr ? w_ext : w_accSum[ACC_W-1:0];
    assign w_ovfNext   = r_accClr ? 1'b0
                                  : (r_ovf | (r_signed ? w_signedOvf : w_accSum[ACC_W]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = CALC;
            CALC:    if (r_cnt == CW'(N - 1)) w_nextState = ACC;
            ACC:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operands are captured only on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_bExt    <= '0;
            r_signed  <= 1'b0;
            r_accClr  <= 1'b0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_bExt   <= {{2{signed_mode & b[OP_W-1]}}, b, 1'b0};
                        r_signed <= signed_mode;
                        r_accClr <= acc_clr;
                        r_sum    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_sum <= r_sum + w_addend;
                    r_cnt <= r_cnt + CW'(1);
                end
                ACC: begin
                    r_product <= w_prod;
                    r_acc     <= w_accNext;
                    r_ovf     <= w_ovfNext;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign product = r_product;
    assign acc     = r_acc;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_booth_r4_mac_seq.sv
// Self-checking bench for booth_r4_mac_seq: directed test-plan steps on OP_W=8
// plus a randomised sweep on OP_W=4, 8 and 16 against an arithmetic reference model.
module tb_booth_r4_mac_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start4 = 0, sm4 = 0, clr4 = 0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, ovf4;
    logic [7:0]  product4;
    logic [11:0] acc4;

    logic        start8 = 0, sm8 = 0, clr8 = 0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, ovf8;
    logic [15:0] product8;
    logic [19:0] acc8;

    logic        start16 = 0, sm16 = 0, clr16 = 0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, ovf16;
    logic [31:0] product16;
    logic [35:0] acc16;

    int checks = 0;
    int errors = 0;
    longint unsigned mAcc[3];
    bit mOvf[3];

    always #5 clk = ~clk;

    booth_r4_mac_seq #(.OP_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .acc_clr(clr4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4), .acc(acc4), .ovf(ovf4));

    booth_r4_mac_seq #(.OP_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .acc_clr(clr8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8), .acc(acc8), .ovf(ovf8));

    booth_r4_mac_seq #(.OP_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .acc_clr(clr16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(product16), .acc(acc16), .ovf(ovf16));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int idxOf(input int w);
        return (w == 4) ? 0 : ((w == 8) ? 1 : 2);
    endfunction

    function automatic logic doneOf(input int w);
        return (w == 4) ? done4 : ((w == 8) ? done8 : done16);
    endfunction

    function automatic logic busyOf(input int w);
        return (w == 4) ? busy4 : ((w == 8) ? busy8 : busy16);
    endfunction

    function automatic logic [63:0] prodOf(input int w);
        return (w == 4) ? 64'(product4) : ((w == 8) ? 64'(product8) : 64'(product16));
    endfunction

    function automatic logic [63:0] accOf(input int w);
        return (w == 4) ? 64'(acc4) : ((w == 8) ? 64'(acc8) : 64'(acc16));
    endfunction

    function automatic logic ovfOf(input int w);
        return (w == 4) ? ovf4 : ((w == 8) ? ovf8 : ovf16);
    endfunction

    // Reference: true integer product, then accumulate modulo 2^ACC_W with the overflow rule.
    task automatic refModel(input int w, input bit sm, input bit clr,
                            input longint unsigned av, input longint unsigned bv,
                            input longint unsigned accIn, input bit ovfIn,
                            output longint unsigned prod, output longint unsigned accOut,
                            output bit ovfOut);
        int accw;
        longint sa, sb, p, accS, trueSum, maxS, minS;
        longint unsigned accMask, extBits;
        accw    = 2 * w + 4;
        accMask = (64'd1 << accw) - 64'd1;
        sa = (sm && av[w-1]) ? longint'(av) - (longint'(1) << w) : longint'(av);
        sb = (sm && bv[w-1]) ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        p = sa * sb;
        prod    = longint'(p) & ((64'd1 << (2 * w)) - 64'd1);
        extBits = longint'(p) & accMask;
        if (clr) begin
            accOut = extBits;
            ovfOut = 1'b0;
        end else begin
            accOut = (accIn + extBits) & accMask;
            if (sm) begin
                accS    = accIn[accw-1] ? longint'(accIn) - (longint'(1) << accw) : longint'(accIn);
                trueSum = accS + p;
                maxS    = (longint'(1) << (accw - 1)) - 1;
                minS    = -(longint'(1) << (accw - 1));
                ovfOut  = ovfIn | (trueSum > maxS) | (trueSum < minS);
            end else begin
                ovfOut = ovfIn | (((accIn + extBits) >> accw) != 0);
            end
        end
    endtask

    task automatic driveStart(input int w, input bit sm, input bit clr, input logic [15:0] av, input logic [15:0] bv);
        case (w)
            4:       begin sm4 = sm;  clr4 = clr;  a4 = av[3:0];  b4 = bv[3:0];  start4 = 1'b1;  end
            8:       begin sm8 = sm;  clr8 = clr;  a8 = av[7:0];  b8 = bv[7:0];  start8 = 1'b1;  end
            default: begin sm16 = sm; clr16 = clr; a16 = av;      b16 = bv;      start16 = 1'b1; end
        endcase
    endtask

    // One full operation: start, count busy cycles, then compare results with the model.
    task automatic applyStimulus(input int w, input bit sm, input bit clr,
                                 input logic [15:0] av, input logic [15:0] bv);
        int busyN, waited, k;
        longint unsigned eProd, eAcc;
        bit eOvf;
        k = idxOf(w);
        @(negedge clk);
        driveStart(w, sm, clr, av, bv);
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0; start16 = 1'b0;
        busyN = 0;
        waited = 0;
        while (!doneOf(w) && waited < 40) begin
            if (busyOf(w)) busyN++;
            waited++;
            @(negedge clk);
        end
        checkOutput($sformatf("done_w%0d", w), 64'(doneOf(w)), 64'd1);
        checkOutput($sformatf("busy_cycles_w%0d", w), 64'(busyN), 64'(w / 2 + 2));
        checkOutput($sformatf("busy_in_done_w%0d", w), 64'(busyOf(w)), 64'd0);
        refModel(w, sm, clr, 64'(av) & ((64'd1 << w) - 1), 64'(bv) & ((64'd1 << w) - 1),
                 mAcc[k], mOvf[k], eProd, eAcc, eOvf);
        mAcc[k] = eAcc;
        mOvf[k] = eOvf;
        checkOutput($sformatf("product_w%0d", w), prodOf(w), 64'(eProd));
        checkOutput($sformatf("acc_w%0d", w), accOf(w), 64'(eAcc));
        checkOutput($sformatf("ovf_w%0d", w), 64'(ovfOf(w)), 64'(eOvf));
    endtask

    function automatic logic [15:0] pickOperand(input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 6))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return m;
            3:       return 16'(32'd1 << (w - 1));
            4:       return m >> 1;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    initial begin
        int dones, waited;
        longint unsigned eProd, eAcc;
        bit eOvf;
        for (int i = 0; i < 3; i++) begin mAcc[i] = 0; mOvf[i] = 0; end

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy8), 64'd0);
        checkOutput("rst_done", 64'(done8), 64'd0);
        checkOutput("rst_product", 64'(product8), 64'd0);
        checkOutput("rst_acc", 64'(acc8), 64'd0);
        checkOutput("rst_ovf", 64'(ovf8), 64'd0);
        rst_n = 1'b1;

        applyStimulus(8, 0, 1, 16'd7, 16'd3);
        checkOutput("tp_7x3_product", 64'(product8), 64'd21);
        checkOutput("tp_7x3_acc", 64'(acc8), 64'd21);

        applyStimulus(8, 1, 1, 16'h0080, 16'h0080);
        checkOutput("tp_m128sq_product", 64'(product8), 64'd16384);
        applyStimulus(8, 1, 0, 16'd127, 16'h00FF);
        checkOutput("tp_127xm1_product", 64'(product8), 64'hFF81);
        checkOutput("tp_127xm1_acc", 64'(acc8), 64'd16257);

        applyStimulus(8, 0, 1, 16'd255, 16'd255);
        for (int i = 0; i < 15; i++) applyStimulus(8, 0, 0, 16'd255, 16'd255);
        checkOutput("tp_16th_acc", 64'(acc8), 64'd1040400);
        checkOutput("tp_16th_ovf", 64'(ovf8), 64'd0);
        applyStimulus(8, 0, 0, 16'd255, 16'd255);
        checkOutput("tp_17th_acc", 64'(acc8), 64'd56849);
        checkOutput("tp_17th_ovf", 64'(ovf8), 64'd1);
        applyStimulus(8, 0, 1, 16'd2, 16'd2);
        checkOutput("tp_clr_ovf", 64'(ovf8), 64'd0);

        // Start held high: done must land exactly every 7 cycles.
        @(negedge clk);
        sm8 = 1'b0; clr8 = 1'b0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        dones = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_done_c%0d", c), 64'(done8), 64'((c % 7) == 0));
            if (done8) begin
                dones++;
                refModel(8, 0, 0, 64'd3, 64'd4, mAcc[1], mOvf[1], eProd, eAcc, eOvf);
                mAcc[1] = eAcc;
                mOvf[1] = eOvf;
                checkOutput("b2b_acc", 64'(acc8), 64'(eAcc));
            end
        end
        start8 = 1'b0;
        checkOutput("b2b_count", 64'(dones), 64'd3);

        // Starts during busy must be ignored, along with the operands presented with them.
        @(negedge clk);
        sm8 = 1'b0; clr8 = 1'b1; a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; clr8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waited = 0;
        while (!done8 && waited < 40) begin waited++; @(negedge clk); end
        checkOutput("ign_done", 64'(done8), 64'd1);
        checkOutput("ign_product", 64'(product8), 64'd30);
        checkOutput("ign_acc", 64'(acc8), 64'd30);
        mAcc[1] = 64'd30;
        mOvf[1] = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checkOutput("ign_no_extra_done", 64'(dones), 64'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        sm8 = 1'b0; clr8 = 1'b0; a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busy8), 64'd0);
        checkOutput("mid_rst_done", 64'(done8), 64'd0);
        checkOutput("mid_rst_product", 64'(product8), 64'd0);
        checkOutput("mid_rst_acc", 64'(acc8), 64'd0);
        checkOutput("mid_rst_ovf", 64'(ovf8), 64'd0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checkOutput("mid_rst_no_done", 64'(dones), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin mAcc[i] = 0; mOvf[i] = 0; end
        applyStimulus(8, 0, 0, 16'd13, 16'd11);
        checkOutput("post_rst_product", 64'(product8), 64'd143);

        // Randomised sweep across widths and modes, first op of each width clears the accumulator.
        for (int wi = 0; wi < 3; wi++) begin
            int w;
            w = (wi == 0) ? 4 : ((wi == 1) ? 8 : 16);
            for (int k = 0; k < 25; k++) begin
                bit sm, clr;
                sm  = 1'($urandom_range(0, 1));
                clr = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                applyStimulus(w, sm, clr, pickOperand(w), pickOperand(w));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
